// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares one FMUL32 multiplier between NREQ requesters.
// Each accepted request drives the multiplier for LATENCY cycles; the
// result and val flag are then captured and returned to the owner.
// Optional macro FMUL_ARB_FIXED_PRIO_EN replaces round-robin selection
// with fixed priority (lowest requester index always wins).
module fmul_arbiter #(
   parameter int NREQ    = 4,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*DATA_W-1:0] req_op1,
   input  logic [NREQ*DATA_W-1:0] req_op2,
   input  logic [NREQ*2-1:0]      req_opc,
   input  logic [NREQ*2-1:0]      req_r_mode,
   output logic [NREQ-1:0]        resp_valid,
   input  logic [NREQ-1:0]        resp_ready,
   output logic [DATA_W-1:0]      resp_data,
   output logic                   resp_flag,
   output logic [DATA_W-1:0]      fmul_op1,
   output logic [DATA_W-1:0]      fmul_op2,
   output logic [1:0]             fmul_opc,
   output logic [1:0]             fmul_r_mode,
   input  logic [DATA_W-1:0]      fmul_result,
   input  logic                   fmul_val,
   output logic                   busy
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [IDX_W-1:0]  r_owner;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  w_start;
   logic [IDX_W-1:0]  w_winner;
   logic              w_found;
   logic              w_accept;

`ifdef FMUL_ARB_FIXED_PRIO_EN
   assign w_start = '0;
`else
   logic [IDX_W-1:0]  r_ptr;

   assign w_start = r_ptr;

   // Round-robin pointer moves just past the requester that was granted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= (w_winner == IDX_W'(NREQ - 1)) ? '0 : w_winner + IDX_W'(1);
      end
   end
`endif

   // Search requesters starting at w_start, wrapping, first valid one wins
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req_valid[(int'(w_start) + k) % NREQ]) begin
            w_found  = 1'b1;
            w_winner = IDX_W'((int'(w_start) + k) % NREQ);
         end
      end
   end

   assign w_accept = (r_state == IDLE) && w_found;
   assign busy     = (r_state != IDLE);

   // Grant is offered only while idle, one-hot at the search winner
   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_winner] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: grant, hold operands for LATENCY cycles, then respond
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_nextState = RESP;
            end
         end
         RESP: begin
            if (resp_ready[r_owner]) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath: latch the winner's operands, count down, capture and release the result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner     <= '0;
         r_cnt       <= '0;
         fmul_op1    <= '0;
         fmul_op2    <= '0;
         fmul_opc    <= '0;
         fmul_r_mode <= '0;
         resp_data   <= '0;
         resp_flag   <= 1'b0;
         resp_valid  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  fmul_op1    <= req_op1[w_winner*DATA_W +: DATA_W];
                  fmul_op2    <= req_op2[w_winner*DATA_W +: DATA_W];
                  fmul_opc    <= req_opc[w_winner*2 +: 2];
                  fmul_r_mode <= req_r_mode[w_winner*2 +: 2];
                  r_owner     <= w_winner;
                  r_cnt       <= CNT_W'(LATENCY);
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  resp_data  <= fmul_result;
                  resp_flag  <= fmul_val;
                  resp_valid <= NREQ'(1) << r_owner;
               end
            end
            RESP: begin
               if (resp_ready[r_owner]) begin
                  resp_valid <= '0;
               end
            end
            default: begin
               resp_valid <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: directed checks for fmul_arbiter with a stand-in FMUL32.
// Build with FMUL_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_fmul_arbiter;

   localparam int NREQ    = 4;
   localparam int DATA_W  = 32;
   localparam int LATENCY = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*DATA_W-1:0] req_op1;
   logic [NREQ*DATA_W-1:0] req_op2;
   logic [NREQ*2-1:0]      req_opc;
   logic [NREQ*2-1:0]      req_r_mode;
   logic [NREQ-1:0]        resp_valid;
   logic [NREQ-1:0]        resp_ready;
   logic [DATA_W-1:0]      resp_data;
   logic                   resp_flag;
   logic [DATA_W-1:0]      fmul_op1;
   logic [DATA_W-1:0]      fmul_op2;
   logic [1:0]             fmul_opc;
   logic [1:0]             fmul_r_mode;
   logic [DATA_W-1:0]      fmul_result;
   logic                   fmul_val;
   logic                   busy;

   int checkCount = 0;
   int errorCount = 0;

   fmul_arbiter #(
      .NREQ    (NREQ),
      .DATA_W  (DATA_W),
      .LATENCY (LATENCY)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op1     (req_op1),
      .req_op2     (req_op2),
      .req_opc     (req_opc),
      .req_r_mode  (req_r_mode),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .resp_flag   (resp_flag),
      .fmul_op1    (fmul_op1),
      .fmul_op2    (fmul_op2),
      .fmul_opc    (fmul_opc),
      .fmul_r_mode (fmul_r_mode),
      .fmul_result (fmul_result),
      .fmul_val    (fmul_val),
      .busy        (busy)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Stand-in multiplier: exact for 1.5*2.0, a reversible mix for everything else
   function automatic logic [31:0] fakeMul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] opc, input logic [1:0] rm);
      if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a ^ {b[15:0], b[31:16]} ^ {28'd0, opc, rm};
   endfunction

   function automatic logic fakeVal(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] opc, input logic [1:0] rm);
      return ^{a, b, opc, rm};
   endfunction

   // Multiplier model responds combinationally to whatever the arbiter drives
   always_comb begin
      fmul_result = fakeMul(fmul_op1, fmul_op2, fmul_opc, fmul_r_mode);
      fmul_val    = fakeVal(fmul_op1, fmul_op2, fmul_opc, fmul_r_mode);
   end

   function automatic logic [31:0] op1Of(input int i);
      return 32'h1111_1111 * 32'(i + 1);
   endfunction

   function automatic logic [31:0] op2Of(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   function automatic logic [1:0] opcOf(input int i);
      return 2'(i);
   endfunction

   function automatic logic [1:0] rmOf(input int i);
      return 2'(3 - i);
   endfunction

   function automatic int oneHotIdx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] op1, input logic [31:0] op2,
                                input logic [1:0] opc, input logic [1:0] rm);
      req_op1[idx*DATA_W +: DATA_W] = op1;
      req_op2[idx*DATA_W +: DATA_W] = op2;
      req_opc[idx*2 +: 2]           = opc;
      req_r_mode[idx*2 +: 2]        = rm;
   endtask

   task automatic loadAll();
      for (int i = 0; i < NREQ; i++) begin
         applyStimulus(i, op1Of(i), op2Of(i), opcOf(i), rmOf(i));
      end
   endtask

   task automatic doReset();
      rst        = 1'b1;
      req_valid  = '0;
      resp_ready = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Safety net so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int expOrder[5];
      int cyc;
      int lastCyc;
      int grants;
      int g;
      logic [NREQ-1:0]   seen;
      logic [DATA_W-1:0] expData;

`ifdef FMUL_ARB_FIXED_PRIO_EN
      expOrder = '{0, 0, 0, 0, 0};
`else
      expOrder = '{0, 1, 2, 3, 0};
`endif

      rst        = 1'b1;
      req_valid  = '0;
      resp_ready = '0;
      req_op1    = '0;
      req_op2    = '0;
      req_opc    = '0;
      req_r_mode = '0;

      // Reset state
      doReset();
      #1;
      checkOutput("rstReqReady",  32'(req_ready),   32'd0);
      checkOutput("rstRespValid", 32'(resp_valid),  32'd0);
      checkOutput("rstRespData",  resp_data,        32'd0);
      checkOutput("rstRespFlag",  32'(resp_flag),   32'd0);
      checkOutput("rstFmulOp1",   fmul_op1,         32'd0);
      checkOutput("rstFmulOp2",   fmul_op2,         32'd0);
      checkOutput("rstFmulOpc",   32'(fmul_opc),    32'd0);
      checkOutput("rstFmulRmode", 32'(fmul_r_mode), 32'd0);
      checkOutput("rstBusy",      32'(busy),        32'd0);

      // Single request from requester 0: 1.5 * 2.0
      applyStimulus(0, 32'h3FC0_0000, 32'h4000_0000, 2'd0, 2'd0);
      req_valid = 4'b0001;
      #1;
      checkOutput("t1ReqReady", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      #1;
      checkOutput("t1FmulOp1",   fmul_op1,         32'h3FC0_0000);
      checkOutput("t1FmulOp2",   fmul_op2,         32'h4000_0000);
      checkOutput("t1Busy",      32'(busy),        32'd1);
      checkOutput("t1ReadyWait", 32'(req_ready),   32'd0);
      checkOutput("t1RespT1",    32'(resp_valid),  32'd0);
      tick();
      checkOutput("t1RespT2",    32'(resp_valid),  32'd0);
      tick();
      checkOutput("t1RespValid", 32'(resp_valid),  32'h1);
      checkOutput("t1RespData",  resp_data,        32'h4040_0000);
      checkOutput("t1RespFlag",  32'(resp_flag),   32'd1);
      resp_ready = 4'b0001;
      tick();
      resp_ready = '0;
      checkOutput("t1RespDone",  32'(resp_valid),  32'd0);
      checkOutput("t1Idle",      32'(busy),        32'd0);

      // All requesters valid, responses always accepted: grant order and spacing
      doReset();
      loadAll();
      req_valid  = 4'b1111;
      resp_ready = 4'b1111;
      cyc     = 0;
      lastCyc = 0;
      grants  = 0;
      while (grants < 5 && cyc < 40) begin
         #1;
         if (req_ready != '0) begin
            g = oneHotIdx(req_ready);
            checkOutput("t2Order",  32'(g), 32'(expOrder[grants]));
            checkOutput("t2OneHot", 32'($countones(req_ready)), 32'd1);
            if (grants > 0) begin
               checkOutput("t2Gap", 32'(cyc - lastCyc), 32'(LATENCY + 2));
            end
            lastCyc = cyc;
            grants++;
            tick();
            cyc++;
            checkOutput("t2Op1",   fmul_op1,         op1Of(g));
            checkOutput("t2Op2",   fmul_op2,         op2Of(g));
            checkOutput("t2Opc",   32'(fmul_opc),    32'(opcOf(g)));
            checkOutput("t2Rmode", 32'(fmul_r_mode), 32'(rmOf(g)));
         end else begin
            tick();
            cyc++;
         end
      end
      checkOutput("t2GrantCount", 32'(grants), 32'd5);
      req_valid = '0;
      for (int i = 0; i < 6; i++) tick();

      // Owner stalls the response while requester 2 waits
      doReset();
      loadAll();
      req_valid = 4'b0001;
      #1;
      checkOutput("t3Grant0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0100;
      tick();
      tick();
      expData = fakeMul(op1Of(0), op2Of(0), opcOf(0), rmOf(0));
      for (int k = 0; k < 5; k++) begin
         checkOutput("t3HoldValid", 32'(resp_valid), 32'h1);
         checkOutput("t3HoldData",  resp_data,       expData);
         checkOutput("t3HoldReady", 32'(req_ready),  32'd0);
         checkOutput("t3HoldBusy",  32'(busy),       32'd1);
         tick();
      end
      resp_ready = 4'b0001;
      #1;
      checkOutput("t3HsReady", 32'(req_ready), 32'd0);
      tick();
      resp_ready = '0;
      checkOutput("t3Grant2",   32'(req_ready),  32'h4);
      checkOutput("t3RespDrop", 32'(resp_valid), 32'd0);
      tick();
      req_valid = '0;
      checkOutput("t3Op1", fmul_op1, op1Of(2));

      // Non-owner resp_ready must not complete requester 2's response
      tick();
      tick();
      resp_ready = 4'b1011;
      expData = fakeMul(op1Of(2), op2Of(2), opcOf(2), rmOf(2));
      checkOutput("t6Data", resp_data, expData);
      for (int k = 0; k < 3; k++) begin
         checkOutput("t6Valid", 32'(resp_valid), 32'h4);
         tick();
      end
      checkOutput("t6StillValid", 32'(resp_valid), 32'h4);
      resp_ready = 4'b0100;
      tick();
      resp_ready = '0;
      checkOutput("t6Done", 32'(resp_valid), 32'd0);

      // Reset during WAIT aborts the operation
      doReset();
      loadAll();
      req_valid = 4'b0010;
      #1;
      checkOutput("t4Grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      checkOutput("t4BusyWait", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t4FmulOp1",   fmul_op1,         32'd0);
      checkOutput("t4FmulOp2",   fmul_op2,         32'd0);
      checkOutput("t4FmulOpc",   32'(fmul_opc),    32'd0);
      checkOutput("t4FmulRmode", 32'(fmul_r_mode), 32'd0);
      checkOutput("t4RespValid", 32'(resp_valid),  32'd0);
      checkOutput("t4RespData",  resp_data,        32'd0);
      checkOutput("t4RespFlag",  32'(resp_flag),   32'd0);
      checkOutput("t4Busy",      32'(busy),        32'd0);
      seen = '0;
      for (int k = 0; k < 6; k++) begin
         tick();
         seen = seen | resp_valid;
      end
      checkOutput("t4NoResp", 32'(seen), 32'd0);
      req_valid = 4'b1000;
      #1;
      checkOutput("t4FreshGrant", 32'(req_ready), 32'h8);
      tick();
      req_valid = '0;
      tick();
      tick();
      checkOutput("t4FreshResp", 32'(resp_valid), 32'h8);
      checkOutput("t4FreshData", resp_data, fakeMul(op1Of(3), op2Of(3), opcOf(3), rmOf(3)));
      resp_ready = 4'b1000;
      tick();
      resp_ready = '0;

      // Pointer wraps after requester 3: 0 then 2
      req_valid = 4'b0101;
      #1;
      checkOutput("t5First", 32'(req_ready), 32'h1);
      tick();
      req_valid  = 4'b0100;
      resp_ready = 4'b1111;
      tick();
      tick();
      tick();
      checkOutput("t5Second", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      checkOutput("t5Op1", fmul_op1, op1Of(2));
      for (int k = 0; k < 4; k++) tick();
      resp_ready = '0;

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
